spio_spinnaker_link_transmitter: RTL and testbench



---
 rtl/spio_spinnaker_link_transmitter_pkg.sv | 56 +++++
 rtl/spio_spinnaker_link_sync.sv | 26 ++
 rtl/spio_spinnaker_link_transmitter.sv | 139 +++++++++++++
 tb/tb_spio_spinnaker_link_transmitter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spio_spinnaker_link_transmitter_pkg.sv
// Shared definitions for the SpiNNaker link transmitter: packet field
// ranges, flit counts, FSM states and the NRZ 2-of-7 symbol encoder.
package spio_spinnaker_link_transmitter_pkg;

    localparam int PKT_W = 72;

    localparam int PKT_HDR_RNG_LO = 0;
    localparam int PKT_HDR_RNG_HI = 7;
    localparam int PKT_KEY_RNG_LO = 8;
    localparam int PKT_KEY_RNG_HI = 39;
    localparam int PKT_PLD_RNG_LO = 40;
    localparam int PKT_PLD_RNG_HI = 71;

    // Header bit that announces a payload
    localparam int PKT_HDR_PLD_BIT = PKT_HDR_RNG_LO + 1;

    localparam logic [4:0] FLITS_SHORT = 5'd10;
    localparam logic [4:0] FLITS_LONG  = 5'd18;

    // Symbol index 16 selects the end-of-packet code
    localparam logic [4:0] SYM_EOP      = 5'd16;
    localparam logic [6:0] NRZ_EOP_CODE = 7'b1100000;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_WAIT,
        TX_WAIT_EOP
    } tx_state_e;

    // NRZ 2-of-7: the new line state is the old one with exactly two wires flipped
    function automatic logic [6:0] encode_nrz_2of7(input logic [4:0] sym,
                                                   input logic [6:0] old);
        logic [6:0] code;
        case (sym)
            5'd0:    code = 7'b0010001;
            5'd1:    code = 7'b0010010;
            5'd2:    code = 7'b0010100;
            5'd3:    code = 7'b0011000;
            5'd4:    code = 7'b0100001;
            5'd5:    code = 7'b0100010;
            5'd6:    code = 7'b0100100;
            5'd7:    code = 7'b0101000;
            5'd8:    code = 7'b1000001;
            5'd9:    code = 7'b1000010;
            5'd10:   code = 7'b1000100;
            5'd11:   code = 7'b1001000;
            5'd12:   code = 7'b0000011;
            5'd13:   code = 7'b0000110;
            5'd14:   code = 7'b0001100;
            5'd15:   code = 7'b0001001;
            default: code = NRZ_EOP_CODE;
        endcase
        return old ^ code;
    endfunction

endpackage

// File: rtl/spio_spinnaker_link_sync.sv
// Multi-flop synchroniser bringing an asynchronous signal into CLK_IN.
// Fewer than two stages is not safe, so the depth is clamped to two.
module spio_spinnaker_link_sync #(
    parameter int SIZE   = 1,
    parameter int STAGES = 2
) (
    input  logic            CLK_IN,
    input  logic [SIZE-1:0] DATA_IN,
    output logic [SIZE-1:0] DATA_OUT
);

    localparam int N = (STAGES < 2) ? 2 : STAGES;

    logic [SIZE-1:0] sync_q [N];

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge CLK_IN) begin
        sync_q[0] <= DATA_IN;
        for (int i = 1; i < N; i++) begin
            sync_q[i] <= sync_q[i-1];
        end
    end

    assign DATA_OUT = sync_q[N-1];

endmodule

// File: rtl/spio_spinnaker_link_transmitter.sv
// SpiNNaker link transmitter: buffers one 72-bit packet, sends it as
// 4-bit flits encoded NRZ 2-of-7, then an EOP symbol. Each symbol waits
// for one transition on the link ACK before the next one is driven.
module spio_spinnaker_link_transmitter
    import spio_spinnaker_link_transmitter_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK_IN,
    input  logic             RESET_IN,
    input  logic [PKT_W-1:0] PKT_DATA_IN,
    input  logic             PKT_VLD_IN,
    output logic             PKT_RDY_OUT,
    output logic [6:0]       SL_DATA_2OF7_OUT,
    input  logic             SL_ACK_IN
);

    logic             ack_sync;
    logic             last_ack_q;
    logic             ack_evt;
    logic             ack_ok;

    tx_state_e        state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             outstanding_q, outstanding_d;
    logic             full_q, full_d;
    logic [PKT_W-1:0] buf_q, buf_d;
    logic [6:0]       data_q, data_d;
    logic             active_q;

    logic             pkt_xfer;
    logic [4:0]       n_flits;
    logic [PKT_W-1:0] buf_shifted;
    logic [3:0]       cur_nibble;

    spio_spinnaker_link_sync #(
        .SIZE   (1),
        .STAGES (SYNC_STAGES)
    ) ack_sync_i (
        .CLK_IN   (CLK_IN),
        .DATA_IN  (SL_ACK_IN),
        .DATA_OUT (ack_sync)
    );

    // A toggle only counts when a symbol is awaiting acknowledgement;
    // anything else is a spurious transition and is dropped
    assign ack_evt = (ack_sync != last_ack_q);
    assign ack_ok  = ack_evt && outstanding_q;

    // Ready stays low through reset and rises on the first edge after it
    assign PKT_RDY_OUT      = active_q && !full_q;
    assign pkt_xfer         = PKT_VLD_IN && PKT_RDY_OUT;
    assign SL_DATA_2OF7_OUT = data_q;

    assign n_flits     = buf_q[PKT_HDR_PLD_BIT] ? FLITS_LONG : FLITS_SHORT;
    assign buf_shifted = buf_q >> {cnt_q, 2'b00};
    assign cur_nibble  = buf_shifted[3:0];

    // State register; last_ack follows the synchroniser even in reset so a
    // level change during reset never looks like a fresh acknowledgement
    always_ff @(posedge CLK_IN) begin
        last_ack_q <= ack_sync;
        if (!RESET_IN) begin
            state_q       <= TX_IDLE;
            cnt_q         <= '0;
            outstanding_q <= 1'b0;
            full_q        <= 1'b0;
            buf_q         <= '0;
            data_q        <= '0;
            active_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            outstanding_q <= outstanding_d;
            full_q        <= full_d;
            buf_q         <= buf_d;
            data_q        <= data_d;
            active_q      <= 1'b1;
        end
    end

    // Next-state logic: accept packets into the buffer and step the symbol
    // sequence one flit per acknowledged symbol
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        outstanding_d = outstanding_q;
        full_d        = full_q;
        buf_d         = buf_q;
        data_d        = data_q;

        if (pkt_xfer) begin
            buf_d  = PKT_DATA_IN;
            full_d = 1'b1;
        end

        case (state_q)
            TX_IDLE: begin
                if (full_q) begin
                    data_d        = encode_nrz_2of7({1'b0, buf_q[3:0]}, data_q);
                    outstanding_d = 1'b1;
                    cnt_d         = 5'd1;
                    state_d       = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (ack_ok) begin
                    outstanding_d = 1'b0;
                    if (cnt_q < n_flits) begin
                        data_d        = encode_nrz_2of7({1'b0, cur_nibble}, data_q);
                        cnt_d         = cnt_q + 5'd1;
                        outstanding_d = 1'b1;
                    end else begin
                        data_d        = encode_nrz_2of7(SYM_EOP, data_q);
                        full_d        = 1'b0;
                        outstanding_d = 1'b1;
                        state_d       = TX_WAIT_EOP;
                    end
                end
            end
            TX_WAIT_EOP: begin
                if (ack_ok) begin
                    outstanding_d = 1'b0;
                    state_d       = TX_IDLE;
                    if (full_q) begin
                        data_d        = encode_nrz_2of7({1'b0, buf_q[3:0]}, data_q);
                        outstanding_d = 1'b1;
                        cnt_d         = 5'd1;
                        state_d       = TX_WAIT;
                    end
                end
            end
            default: begin
                state_d = TX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spio_spinnaker_link_transmitter.sv
// Bench for the SpiNNaker link transmitter: a driver pushes expected
// symbols into a scoreboard, a link-side monitor pops and compares every
// symbol, decodes packets back, and a responder returns the ACK toggles.
`timescale 1ns/1ps
module tb_spio_spinnaker_link_transmitter;

    localparam int SYNC_STAGES = 2;
    localparam int ACK_LAT     = SYNC_STAGES + 1;

    logic        CLK_IN;
    logic        RESET_IN;
    logic [71:0] PKT_DATA_IN;
    logic        PKT_VLD_IN;
    logic        PKT_RDY_OUT;
    logic [6:0]  SL_DATA_2OF7_OUT;
    logic        SL_ACK_IN;

    typedef struct {
        logic [6:0] sym;
        bit         tied;
    } exp_t;

    exp_t        expQ[$];
    logic [71:0] pktQ[$];
    int          pktLenQ[$];
    logic [6:0]  obsLog[$];

    logic [6:0]  tbCode [17] = '{7'h11, 7'h12, 7'h14, 7'h18, 7'h21, 7'h22, 7'h24, 7'h28,
                                 7'h41, 7'h42, 7'h44, 7'h48, 7'h03, 7'h06, 7'h0C, 7'h09,
                                 7'h60};
    logic [6:0]  shortRef [11] = '{7'h11, 7'h00, 7'h12, 7'h03, 7'h12, 7'h03,
                                   7'h12, 7'h03, 7'h12, 7'h03, 7'h63};

    logic [6:0]  expOld;
    int          nVec;
    int          nFail;
    int          symCount;
    int          ackOwed;
    int          cycleCnt;
    int          lastToggleCycle;
    bit          stall;

    spio_spinnaker_link_transmitter #(
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .CLK_IN           (CLK_IN),
        .RESET_IN         (RESET_IN),
        .PKT_DATA_IN      (PKT_DATA_IN),
        .PKT_VLD_IN       (PKT_VLD_IN),
        .PKT_RDY_OUT      (PKT_RDY_OUT),
        .SL_DATA_2OF7_OUT (SL_DATA_2OF7_OUT),
        .SL_ACK_IN        (SL_ACK_IN)
    );

    // 150 MHz clock
    initial begin
        CLK_IN = 1'b0;
        forever #3.333 CLK_IN = ~CLK_IN;
    end

    // Cycle counter used to measure ACK-to-symbol latency
    initial begin
        cycleCnt = 0;
        forever begin
            @(posedge CLK_IN);
            cycleCnt++;
        end
    end

    // Watchdog so the run can never hang
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
        nVec++;
        if (act !== req) begin
            nFail++;
            $display("[TB] FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cycleCnt);
        end
    endtask

    task automatic failNow(input string name, input string detail);
        nVec++;
        nFail++;
        $display("[TB] FAIL %s: %s at cycle %0d", name, detail, cycleCnt);
    endtask

    // Model: chain the expected NRZ line state through every flit and the EOP
    task automatic pushExpected(input logic [71:0] pkt, input bit tiedFirst);
        exp_t e;
        int   n;
        n = pkt[1] ? 18 : 10;
        for (int i = 0; i < n; i++) begin
            expOld = expOld ^ tbCode[pkt[4*i +: 4]];
            e.sym  = expOld;
            e.tied = (i > 0) || tiedFirst;
            expQ.push_back(e);
        end
        expOld = expOld ^ tbCode[16];
        e.sym  = expOld;
        e.tied = 1'b1;
        expQ.push_back(e);
        pktQ.push_back(pkt);
        pktLenQ.push_back(n);
    endtask

    // Offer one packet; the transfer happens on the posedge after RDY is seen high
    task automatic applyStimulus(input logic [71:0] pkt, input bit tiedFirst, input bit keepVld);
        int t;
        PKT_DATA_IN = pkt;
        PKT_VLD_IN  = 1'b1;
        t = 0;
        while (!PKT_RDY_OUT && t < 4000) begin
            @(negedge CLK_IN);
            t++;
        end
        if (!PKT_RDY_OUT) begin
            failNow("pktAcceptTimeout", "PKT_RDY_OUT never rose, required=1");
        end else begin
            pushExpected(pkt, tiedFirst);
        end
        @(negedge CLK_IN);
        if (!keepVld) PKT_VLD_IN = 1'b0;
    endtask

    task automatic waitDrain();
        int t;
        t = 0;
        while ((expQ.size() != 0 || ackOwed != 0) && t < 6000) begin
            @(negedge CLK_IN);
            t++;
        end
        if (expQ.size() != 0 || ackOwed != 0)
            failNow("drainTimeout", $sformatf("pending=%0d required=0", expQ.size()));
        repeat (8) @(negedge CLK_IN);
    endtask

    task automatic waitSymbols(input int target);
        int t;
        t = 0;
        while (symCount < target && t < 4000) begin
            @(negedge CLK_IN);
            t++;
        end
        if (symCount < target)
            failNow("symbolTimeout", $sformatf("symbols=%0d required=%0d", symCount, target));
    endtask

    // Link receiver: respond to each symbol with one ACK toggle 23 ns later
    initial begin
        forever begin
            wait (ackOwed > 0);
            #23;
            wait (!stall);
            ackOwed--;
            SL_ACK_IN       = ~SL_ACK_IN;
            lastToggleCycle = cycleCnt;
        end
    end

    // Monitor: every change on the link is one symbol; score it and decode it
    initial begin
        logic [6:0]  prevOut;
        logic [6:0]  cur;
        logic [6:0]  diff;
        logic [71:0] asmPkt;
        logic [71:0] refPkt;
        int          asmN;
        int          refN;
        int          idx;
        exp_t        e;
        prevOut = '0;
        asmPkt  = '0;
        asmN    = 0;
        forever begin
            @(negedge CLK_IN);
            if (!RESET_IN) begin
                prevOut = SL_DATA_2OF7_OUT;
                asmPkt  = '0;
                asmN    = 0;
            end else if (SL_DATA_2OF7_OUT !== prevOut) begin
                cur     = SL_DATA_2OF7_OUT;
                diff    = cur ^ prevOut;
                prevOut = cur;
                symCount++;
                ackOwed++;
                obsLog.push_back(cur);
                if (expQ.size() == 0) begin
                    failNow("unexpectedSymbol", $sformatf("actual=%0h required=none", cur));
                end else begin
                    e = expQ.pop_front();
                    checkOutput("symbol", 72'(cur), 72'(e.sym));
                    if (e.tied)
                        checkOutput("ackLatency", 72'(cycleCnt - lastToggleCycle), 72'(ACK_LAT));
                end
                idx = -1;
                for (int k = 0; k < 17; k++) if (diff == tbCode[k]) idx = k;
                if (idx < 0) begin
                    failNow("decode", $sformatf("transition=%0h required=2of7", diff));
                end else if (idx == 16) begin
                    checkOutput("rdyOnEop", 72'(PKT_RDY_OUT), 72'(1));
                    if (pktQ.size() > 0) begin
                        refPkt = pktQ.pop_front();
                        refN   = pktLenQ.pop_front();
                        if (refN == 10) refPkt[71:40] = '0;
                        checkOutput("decodedPacket", asmPkt, refPkt);
                        checkOutput("flitCount", 72'(asmN), 72'(refN));
                    end
                    asmPkt = '0;
                    asmN   = 0;
                end else begin
                    if (asmN < 18) asmPkt[4*asmN +: 4] = idx[3:0];
                    asmN++;
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        int         s;
        logic [6:0] held;
        nVec            = 0;
        nFail           = 0;
        symCount        = 0;
        ackOwed         = 0;
        lastToggleCycle = 0;
        stall           = 1'b0;
        expOld          = '0;
        RESET_IN        = 1'b0;
        PKT_VLD_IN      = 1'b0;
        PKT_DATA_IN     = '0;
        SL_ACK_IN       = 1'b0;

        repeat (5) @(negedge CLK_IN);
        checkOutput("resetData", 72'(SL_DATA_2OF7_OUT), 72'(0));
        checkOutput("resetRdy", 72'(PKT_RDY_OUT), 72'(0));
        RESET_IN = 1'b1;
        @(negedge CLK_IN);
        checkOutput("rdyAfterRelease", 72'(PKT_RDY_OUT), 72'(1));

        $display("[TB] short packet");
        obsLog.delete();
        applyStimulus({32'h0, 32'h0000_0001, 8'h00}, 1'b0, 1'b0);
        waitDrain();
        checkOutput("shortSymbolCount", 72'(obsLog.size()), 72'(11));
        for (int i = 0; i < 11; i++)
            if (i < obsLog.size()) checkOutput($sformatf("shortSym%0d", i), 72'(obsLog[i]), 72'(shortRef[i]));

        $display("[TB] long packet");
        obsLog.delete();
        applyStimulus({32'ha5a5_a5a5, 32'h0000_0001, 8'h02}, 1'b0, 1'b0);
        waitDrain();
        checkOutput("longSymbolCount", 72'(obsLog.size()), 72'(19));

        $display("[TB] back-to-back");
        for (int i = 0; i < 8; i++)
            applyStimulus({32'h1357_9bdf ^ (32'h1111_1111 * i), 32'hc0de_0000 + i,
                           (i[0] ? 8'h02 : 8'h00) | 8'h50}, i > 0, 1'b1);
        PKT_VLD_IN = 1'b0;
        waitDrain();

        $display("[TB] ack stall");
        s = symCount;
        applyStimulus({32'hfeed_beef, 32'h8765_4321, 8'h02}, 1'b0, 1'b0);
        waitSymbols(s + 5);
        stall = 1'b1;
        held  = SL_DATA_2OF7_OUT;
        repeat (500) @(negedge CLK_IN);
        checkOutput("stallData", 72'(SL_DATA_2OF7_OUT), 72'(held));
        checkOutput("stallRdy", 72'(PKT_RDY_OUT), 72'(0));
        checkOutput("stallSymbols", 72'(symCount), 72'(s + 5));
        stall = 1'b0;
        waitDrain();

        $display("[TB] spurious ack");
        s    = symCount;
        held = SL_DATA_2OF7_OUT;
        SL_ACK_IN       = ~SL_ACK_IN;
        lastToggleCycle = cycleCnt;
        repeat (20) @(negedge CLK_IN);
        checkOutput("spuriousSymbols", 72'(symCount), 72'(s));
        checkOutput("spuriousData", 72'(SL_DATA_2OF7_OUT), 72'(held));
        applyStimulus({32'h0, 32'h89ab_cdef, 8'h31}, 1'b0, 1'b0);
        waitDrain();

        $display("[TB] reset mid-packet");
        s = symCount;
        applyStimulus({32'h0f0f_0f0f, 32'h2468_ace0, 8'h02}, 1'b0, 1'b0);
        waitSymbols(s + 5);
        RESET_IN = 1'b0;
        repeat (20) @(negedge CLK_IN);
        checkOutput("midResetData", 72'(SL_DATA_2OF7_OUT), 72'(0));
        checkOutput("midResetRdy", 72'(PKT_RDY_OUT), 72'(0));
        checkOutput("midResetSymbols", 72'(symCount), 72'(s + 5));
        expQ.delete();
        pktQ.delete();
        pktLenQ.delete();
        expOld = '0;
        RESET_IN = 1'b1;
        @(negedge CLK_IN);
        checkOutput("rdyAfterMidReset", 72'(PKT_RDY_OUT), 72'(1));
        obsLog.delete();
        applyStimulus({32'h0, 32'h0000_0001, 8'h00}, 1'b0, 1'b0);
        waitDrain();
        if (obsLog.size() > 0) checkOutput("firstAfterReset", 72'(obsLog[0]), 72'(7'h11));
        else failNow("firstAfterReset", "no symbol, required=11");

        checkOutput("scoreboardEmpty", 72'(expQ.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
